// File: rtl/alu_seq_pkg.sv
// Shared constants for the ALU issue sequencer: op codes, funct codes,
// the R-type ALUop value and the sequencer state encoding.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_MOVE = 4'b0100;
  localparam logic [3:0] OP_SWAP = 4'b0101;
  localparam logic [3:0] OP_NOP  = 4'b1111;

  localparam logic [3:0] FUNCT_ADD  = 4'b0000;
  localparam logic [3:0] FUNCT_SUB  = 4'b0010;
  localparam logic [3:0] FUNCT_MUL  = 4'b0100;
  localparam logic [3:0] FUNCT_DIV  = 4'b0101;
  localparam logic [3:0] FUNCT_MOVE = 4'b0111;
  localparam logic [3:0] FUNCT_SWAP = 4'b1000;

  localparam logic [1:0] ALUOP_RTYPE = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WB    = 3'd3,
    ST_WB2   = 3'd4
  } state_t;

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational funct/ALUop decode to the 4-bit ALU op code.
// Non-R-type instructions decode to NOP silently; an unmapped funct on an
// R-type instruction decodes to NOP and raises illegal.
module alu_seq_decode
  import alu_seq_pkg::*;
(
  input  logic [3:0] funct,
  input  logic [1:0] alu_op,
  output logic [3:0] op,
  output logic       illegal
);

  // funct lookup, only meaningful for R-type instructions
  always_comb begin
    op      = OP_NOP;
    illegal = 1'b0;
    if (alu_op == ALUOP_RTYPE) begin
      case (funct)
        FUNCT_ADD:  op = OP_ADD;
        FUNCT_SUB:  op = OP_SUB;
        FUNCT_MUL:  op = OP_MUL;
        FUNCT_DIV:  op = OP_DIV;
        FUNCT_MOVE: op = OP_MOVE;
        FUNCT_SWAP: op = OP_SWAP;
        default:    illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle ALU issue controller: accepts one instruction at a time,
// holds the ALU op for its latency and sequences register write-back
// (two writes for swap).
// Optional build macro ALU_SEQ_PERF_EN adds saturating perf_issued and
// perf_wait counters.
//
// state    | meaning
// IDLE     | ready for a new instruction, ALU op is NOP
// ISSUE    | one-cycle alu_start pulse, latency counter loaded for mul/div
// WAIT     | mul/div in flight, counter runs LAT..1
// WB       | write ALU result to rd
// WB2      | swap only: write second operand to rs
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 8,
  parameter int REG_AW  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        funct,
  input  logic [1:0]        alu_op,
  input  logic [REG_AW-1:0] rd,
  input  logic [REG_AW-1:0] rs,
  output logic [3:0]        alu_operation,
  output logic              alu_start,
  output logic              wb_en,
  output logic [REG_AW-1:0] wb_addr,
  output logic              wb_sel,
  output logic              illegal,
  output logic              busy
`ifdef ALU_SEQ_PERF_EN
  ,
  output logic [15:0]       perf_issued,
  output logic [15:0]       perf_wait
`endif
);

  localparam logic [3:0] MUL_LAT_C = 4'(MUL_LAT);
  localparam logic [3:0] DIV_LAT_C = 4'(DIV_LAT);

  state_t            state, state_nxt;
  logic [3:0]        op_q;
  logic [3:0]        cnt_q;
  logic [REG_AW-1:0] rd_q, rs_q;
  logic              illegal_q;
  logic [3:0]        dec_op;
  logic              dec_illegal;
  logic              transfer;

  alu_seq_decode u_decode (
    .funct   (funct),
    .alu_op  (alu_op),
    .op      (dec_op),
    .illegal (dec_illegal)
  );

  assign transfer = in_valid && in_ready;
  assign busy     = (state != ST_IDLE);
  assign illegal  = illegal_q;

  // state register, latched instruction fields and latency counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      op_q      <= OP_NOP;
      rd_q      <= '0;
      rs_q      <= '0;
      cnt_q     <= 4'd0;
      illegal_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      illegal_q <= transfer && dec_illegal;
      if (transfer) begin
        op_q <= dec_op;
        rd_q <= rd;
        rs_q <= rs;
      end
      if (state == ST_ISSUE) begin
        if (op_q == OP_MUL)      cnt_q <= MUL_LAT_C;
        else if (op_q == OP_DIV) cnt_q <= DIV_LAT_C;
      end else if (state == ST_WAIT) begin
        cnt_q <= cnt_q - 4'd1;
      end
    end
  end

  // next-state and Moore outputs; op is driven to the ALU for every busy state
  always_comb begin
    state_nxt     = state;
    in_ready      = 1'b0;
    alu_operation = OP_NOP;
    alu_start     = 1'b0;
    wb_en         = 1'b0;
    wb_addr       = '0;
    wb_sel        = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid && (dec_op != OP_NOP)) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        alu_operation = op_q;
        alu_start     = 1'b1;
        state_nxt     = ((op_q == OP_MUL) || (op_q == OP_DIV)) ? ST_WAIT : ST_WB;
      end
      ST_WAIT: begin
        alu_operation = op_q;
        if (cnt_q == 4'd1) state_nxt = ST_WB;
      end
      ST_WB: begin
        alu_operation = op_q;
        wb_en         = 1'b1;
        wb_addr       = rd_q;
        state_nxt     = (op_q == OP_SWAP) ? ST_WB2 : ST_IDLE;
      end
      ST_WB2: begin
        alu_operation = op_q;
        wb_en         = 1'b1;
        wb_addr       = rs_q;
        wb_sel        = 1'b1;
        state_nxt     = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

`ifdef ALU_SEQ_PERF_EN
  // saturating counts of issue cycles and multi-cycle wait cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issued <= 16'd0;
      perf_wait   <= 16'd0;
    end else begin
      if ((state == ST_ISSUE) && (perf_issued != 16'hFFFF)) perf_issued <= perf_issued + 16'd1;
      if ((state == ST_WAIT) && (perf_wait != 16'hFFFF))    perf_wait   <= perf_wait + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: a per-cycle schedule model (queue
// of expected output slots pushed at each accepted instruction) compared on
// every falling edge, plus directed literal checks of the key timings.
module tb_alu_sequencer;

  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 8;
  localparam int AW      = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [3:0]    funct = 4'd0;
  logic [1:0]    alu_op = 2'd0;
  logic [AW-1:0] rd = '0;
  logic [AW-1:0] rs = '0;
  logic          in_ready;
  logic [3:0]    alu_operation;
  logic          alu_start, wb_en, wb_sel, illegal, busy;
  logic [AW-1:0] wb_addr;
`ifdef ALU_SEQ_PERF_EN
  logic [15:0]   perf_issued, perf_wait;
`endif

  always #5 clk = ~clk;

  alu_sequencer #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .REG_AW(AW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .funct         (funct),
    .alu_op        (alu_op),
    .rd            (rd),
    .rs            (rs),
    .alu_operation (alu_operation),
    .alu_start     (alu_start),
    .wb_en         (wb_en),
    .wb_addr       (wb_addr),
    .wb_sel        (wb_sel),
    .illegal       (illegal),
    .busy          (busy)
`ifdef ALU_SEQ_PERF_EN
    ,
    .perf_issued   (perf_issued),
    .perf_wait     (perf_wait)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference decode straight from the instruction table
  function automatic logic [3:0] ref_op(input logic [3:0] f, input logic [1:0] a);
    if (a != 2'b11) return 4'hF;
    case (f)
      4'h0: return 4'h0;
      4'h2: return 4'h1;
      4'h4: return 4'h2;
      4'h5: return 4'h3;
      4'h7: return 4'h4;
      4'h8: return 4'h5;
      default: return 4'hF;
    endcase
  endfunction

  typedef struct {
    logic [3:0]    op;
    logic          start;
    logic          wb;
    logic [AW-1:0] addr;
    logic          sel;
  } slot_t;

  slot_t sched[$];
  logic  ill_exp = 1'b0;

  // model: each accepted instruction expands into its list of busy cycles
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      sched.delete();
      ill_exp = 1'b0;
    end else begin
      automatic logic       xfer = in_valid && (sched.size() == 0);
      automatic logic [3:0] op   = ref_op(funct, alu_op);
      automatic int         lat  = 0;
      if (sched.size() > 0) void'(sched.pop_front());
      ill_exp = xfer && (alu_op == 2'b11) && (op == 4'hF);
      if (xfer && op != 4'hF) begin
        if (op == 4'h2) lat = MUL_LAT;
        if (op == 4'h3) lat = DIV_LAT;
        sched.push_back('{op: op, start: 1'b1, wb: 1'b0, addr: '0, sel: 1'b0});
        for (int i = 0; i < lat; i++)
          sched.push_back('{op: op, start: 1'b0, wb: 1'b0, addr: '0, sel: 1'b0});
        sched.push_back('{op: op, start: 1'b0, wb: 1'b1, addr: rd, sel: 1'b0});
        if (op == 4'h5)
          sched.push_back('{op: op, start: 1'b0, wb: 1'b1, addr: rs, sel: 1'b1});
      end
    end
  end

  // compare every cycle against the model
  initial forever begin
    @(negedge clk);
    if (sched.size() == 0) begin
      chk("m_op", alu_operation, 4'hF);
      chk("m_start", alu_start, 1'b0);
      chk("m_wb_en", wb_en, 1'b0);
      chk("m_ready", in_ready, 1'b1);
      chk("m_busy", busy, 1'b0);
    end else begin
      chk("m_op", alu_operation, sched[0].op);
      chk("m_start", alu_start, sched[0].start);
      chk("m_wb_en", wb_en, sched[0].wb);
      if (sched[0].wb) begin
        chk("m_wb_addr", wb_addr, sched[0].addr);
        chk("m_wb_sel", wb_sel, sched[0].sel);
      end
      chk("m_ready", in_ready, 1'b0);
      chk("m_busy", busy, 1'b1);
    end
    chk("m_illegal", illegal, ill_exp);
  end

  task automatic send(input logic [3:0] f, input logic [1:0] a, input logic [AW-1:0] d, input logic [AW-1:0] s);
    @(negedge clk); #1;
    in_valid = 1'b1; funct = f; alu_op = a; rd = d; rs = s;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int hold, wbs, wb_cyc, idle_cyc, sub_at;
    logic [3:0] fl [6];
    fl = '{4'h0, 4'h2, 4'h4, 4'h5, 4'h7, 4'h8};

    // reset values
    #2;
    chk("rst_op", alu_operation, 4'hF);
    chk("rst_start", alu_start, 1'b0);
    chk("rst_wb", {wb_en, wb_sel, 29'd0, 3'(wb_addr)} == 32'd0, 1'b1);
    chk("rst_illegal", illegal, 1'b0);
    chk("rst_busy", busy, 1'b0);
`ifdef ALU_SEQ_PERF_EN
    chk("rst_perf", {perf_issued, perf_wait}, 32'd0);
`endif
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

    // add, rd=2
    send(4'h0, 2'b11, 3'd2, 3'd0);
    @(negedge clk);
    chk("add_start", alu_start, 1'b1);
    chk("add_op", alu_operation, 4'h0);
    @(negedge clk);
    chk("add_wb_en", wb_en, 1'b1);
    chk("add_wb_addr", wb_addr, 3'd2);
    chk("add_wb_sel", wb_sel, 1'b0);
    @(negedge clk);
    chk("add_ready", in_ready, 1'b1);

    // div: op held ISSUE+LAT+WB cycles, single write at T+10, idle at T+11
    send(4'h5, 2'b11, 3'd4, 3'd0);
    hold = 0; wbs = 0; wb_cyc = 0; idle_cyc = 0;
    for (int i = 1; i <= 30 && idle_cyc == 0; i++) begin
      @(negedge clk);
      if (alu_operation == 4'h3) hold++;
      if (wb_en) begin wbs++; wb_cyc = i; end
      if (!busy) idle_cyc = i;
    end
    chk("div_hold", hold, 32'd10);
    chk("div_wbs", wbs, 32'd1);
    chk("div_wb_cycle", wb_cyc, 32'd10);
    chk("div_idle_cycle", idle_cyc, 32'd11);

    // swap rd=3 rs=5
    send(4'h8, 2'b11, 3'd3, 3'd5);
    @(negedge clk);
    chk("swap_op", alu_operation, 4'h5);
    @(negedge clk);
    chk("swap_wb1", {wb_en, wb_sel, 1'b0, wb_addr}, {1'b1, 1'b0, 1'b0, 3'd3});
    @(negedge clk);
    chk("swap_wb2", {wb_en, wb_sel, 1'b0, wb_addr}, {1'b1, 1'b1, 1'b0, 3'd5});
    @(negedge clk);
    chk("swap_ready", in_ready, 1'b1);

    // swap with rd==rs
    send(4'h8, 2'b11, 3'd6, 3'd6);
    @(negedge clk);
    @(negedge clk);
    chk("swapeq_wb1", {wb_en, wb_sel, 1'b0, wb_addr}, {1'b1, 1'b0, 1'b0, 3'd6});
    @(negedge clk);
    chk("swapeq_wb2", {wb_en, wb_sel, 1'b0, wb_addr}, {1'b1, 1'b1, 1'b0, 3'd6});

    // illegal funct on R-type
    wait_idle();
    send(4'hF, 2'b11, 3'd1, 3'd1);
    @(negedge clk);
    chk("ill_pulse", illegal, 1'b1);
    chk("ill_no_start", alu_start, 1'b0);
    chk("ill_ready", in_ready, 1'b1);
    @(negedge clk);
    chk("ill_clear", illegal, 1'b0);

    // same funct, non-R-type: nothing happens
    send(4'hF, 2'b00, 3'd1, 3'd1);
    @(negedge clk);
    chk("nop_illegal", illegal, 1'b0);
    chk("nop_busy", busy, 1'b0);

    // reset in the middle of a divide
    send(4'h5, 2'b11, 3'd1, 3'd0);
    repeat (4) @(negedge clk);
    chk("mid_busy_pre", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_op", alu_operation, 4'hF);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_ready", in_ready, 1'b1);
    chk("mid_rst_wb", wb_en, 1'b0);
    @(negedge clk); #1 rst_n = 1'b1;
    wbs = 0;
    repeat (15) begin
      @(negedge clk);
      if (wb_en) wbs++;
    end
    chk("mid_rst_no_wb", wbs, 32'd0);

    // back-to-back: mult then sub with in_valid held high
    @(negedge clk); #1;
    in_valid = 1'b1; funct = 4'h4; alu_op = 2'b11; rd = 3'd1; rs = 3'd0;
    @(posedge clk); #1;
    funct = 4'h2; rd = 3'd2;
    sub_at = 0;
    for (int i = 1; i <= 20 && sub_at == 0; i++) begin
      @(negedge clk);
      if (alu_start && i > 1) begin
        sub_at = i;
        chk("b2b_sub_op", alu_operation, 4'h1);
      end
    end
    #1 in_valid = 1'b0;
    chk("b2b_sub_issue", sub_at, 32'd7);
    wait_idle();
`ifdef ALU_SEQ_PERF_EN
    chk("perf_issued", perf_issued, 16'd2);
    chk("perf_wait", perf_wait, 16'(MUL_LAT));
`endif

    // randomized traffic checked by the model
    for (int c = 0; c < 800; c++) begin
      @(negedge clk); #1;
      in_valid = ($urandom_range(0, 99) < 60);
      funct    = ($urandom_range(0, 9) < 8) ? fl[$urandom_range(0, 5)] : 4'($urandom_range(0, 15));
      alu_op   = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      rd       = AW'($urandom_range(0, (1 << AW) - 1));
      rs       = AW'($urandom_range(0, (1 << AW) - 1));
    end
    #1 in_valid = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Multi-cycle issue controller sitting between instruction decode and the ALU/register-file write port.
- Accepts one ALU instruction at a time via a valid/ready handshake and decodes funct/ALUop to the 4-bit ALU operation code.
- Holds the operation stable for the op's latency (1 cycle for add/sub/move, parameterised for mult/div).
- Sequences register-file write-back, including the two-write swap.

Parameters:
- MUL_LAT, 3, wait cycles for multiply after issue; legal range 1..15.
- DIV_LAT, 8, wait cycles for divide after issue; legal range 1..15.
- REG_AW, 3, register address width.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  instruction present
- in_ready  out  1  sequencer can accept
- funct  in  4  function field
- alu_op  in  2  ALUop field; 2'b11 = R-type ALU instruction
- rd  in  REG_AW  destination register
- rs  in  REG_AW  source register, second destination for swap
- alu_operation  out  4  op code to ALU
- alu_start  out  1  one-cycle pulse at issue
- wb_en  out  1  register-file write strobe
- wb_addr  out  REG_AW  write address
- wb_sel  out  1  write-data select: 0 = ALU result, 1 = swap second operand
- illegal  out  1  one-cycle pulse on unmapped funct with alu_op==11
- busy  out  1  state != IDLE

Behaviour:
- Reset values (asynchronous, rst_n low):
  - state=IDLE, alu_operation=4'b1111, alu_start=0, wb_en=0, wb_addr=0, wb_sel=0, illegal=0, counter=0.
  - Reset mid-operation abandons the instruction; no write-back occurs.
- in_ready = (state==IDLE). Transfer occurs when in_valid && in_ready; funct, alu_op, rd and rs are latched at that edge.
- Decode, only when alu_op==11:
  - funct 0000 -> add 0000
  - funct 0010 -> sub 0001
  - funct 0100 -> mult 0010
  - funct 0101 -> div 0011
  - funct 0111 -> move 0100
  - funct 1000 -> swap 0101
  - any other funct -> 1111
- alu_op != 11: decodes to nop 1111 and is not illegal.
- States: IDLE, ISSUE, WAIT, WB, WB2.
- IDLE:
  - On transfer with op 1111: stay in IDLE; illegal=1 on the next cycle only if alu_op==11; no issue, no write.
  - Other ops: go to ISSUE.
- ISSUE (1 cycle):
  - alu_operation=op, alu_start=1.
  - mult/div: load counter with MUL_LAT/DIV_LAT, go to WAIT.
  - Other ops: go to WB.
- WAIT: decrement the counter each cycle; when counter==1, go to WB. WAIT lasts exactly LAT cycles.
- WB (1 cycle): wb_en=1, wb_addr=rd, wb_sel=0. Swap goes to WB2; all other ops go to IDLE.
- WB2 (1 cycle): wb_en=1, wb_addr=rs, wb_sel=1, then go to IDLE.
- alu_operation holds op from ISSUE through the last WB cycle; it is 1111 in IDLE.
- Latency, with transfer at edge T:
  - add/sub/move: ISSUE T+1, WB T+2, in_ready high T+3.
  - mult/div: write-back at T+2+LAT.
  - swap: WB T+2, WB2 T+3.
- Back-to-back: a new transfer is possible in the first IDLE cycle; there is no bubble beyond that.
- Swap with rd==rs: both writes still occur, WB2 last.
- in_valid dropping while busy has no effect; latched fields are used.

Optional Feature:
- Macro: ALU_SEQ_PERF_EN.
- When defined:
  - Extra outputs perf_issued (16 bits) and perf_wait (16 bits).
  - perf_issued increments on every ISSUE cycle.
  - perf_wait increments on every WAIT cycle.
  - Both saturate at 16'hFFFF and reset to 0 on rst_n.
- When undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package alu_seq_pkg:
  - ALU op-code constants (OP_ADD..OP_SWAP, OP_NOP=4'b1111).
  - funct constants.
  - ALUOP_RTYPE=2'b11.
  - State encoding.
- Sub-module alu_seq_decode: combinational funct/alu_op -> op code plus illegal flag, instantiated once in alu_sequencer.

Test Plan:
- Reset: hold rst_n=0 mid-divide (WAIT) -> all outputs at reset values immediately; no wb_en after release.
- add: funct=0000, alu_op=11, rd=2 -> alu_start at T+1 with op 0000; wb_en at T+2 with wb_addr=2, wb_sel=0; in_ready at T+3.
- div, DIV_LAT=8: funct=0101 -> op 0011 held 10 cycles; single wb_en at T+10; busy low at T+11.
- swap: funct=1000, rd=3, rs=5 -> WB at T+2 (addr 3, sel 0), WB2 at T+3 (addr 5, sel 1).
- Illegal/nop: funct=1111 with alu_op=11 -> illegal pulse at T+1, no alu_start, in_ready stays high; same funct with alu_op=00 -> no illegal, no activity.
- Back-to-back: in_valid held high with mult then sub queued -> second transfer exactly at the first IDLE cycle; with ALU_SEQ_PERF_EN, perf_issued=2 and perf_wait=MUL_LAT.
